// File: rtl/sid_dca_pkg.sv
// sid_dca_pkg -- shared types and default widths for the SID DCA scheduler.
//   dca_state_t : pass sequencer states (IDLE, MUL, DRAIN, COMMIT)
//   DEF_*       : default widths / voice count
//   round_bias  : half-LSB bias added before truncation when rounding is built in
package sid_dca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DRAIN,
    COMMIT
  } dca_state_t;

  localparam int unsigned DEF_NUM_VOICES = 3;
  localparam int unsigned DEF_WAVE_W     = 12;
  localparam int unsigned DEF_ENV_W      = 8;
  localparam int unsigned DEF_OUT_W      = 12;
  localparam int unsigned PROD_W         = DEF_WAVE_W + DEF_ENV_W;

  // Half of the weight of the lowest kept product bit; 0 when nothing is dropped.
  function automatic int unsigned round_bias(input int unsigned prod_w,
                                             input int unsigned out_w);
    if (prod_w > out_w)
      return 32'd1 << (prod_w - out_w - 1);
    else
      return 0;
  endfunction

endpackage

// File: rtl/sid_dca_if.sv
// sid_dca_if -- voice-side inputs and mixer-side outputs of the DCA scheduler.
//   ce_1m      : 1 MHz sample strobe, one clock wide
//   wave_in    : voice k waveform at [k*WAVE_W +: WAVE_W]
//   env_in     : voice k envelope at [k*ENV_W +: ENV_W]
//   signal_out : committed DCA outputs, voice k at [k*OUT_W +: OUT_W]
//   done       : one-clock pulse in the cycle signal_out updates
//   busy       : sample pass in progress
//   overrun    : sticky, ce_1m seen while busy
// Modports: master (voice/mixer side), slave (scheduler).
interface sid_dca_if #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned WAVE_W     = 12,
  parameter int unsigned ENV_W      = 8,
  parameter int unsigned OUT_W      = 12
);

  logic                         ce_1m;
  logic [NUM_VOICES*WAVE_W-1:0] wave_in;
  logic [NUM_VOICES*ENV_W-1:0]  env_in;
  logic [NUM_VOICES*OUT_W-1:0]  signal_out;
  logic                         done;
  logic                         busy;
  logic                         overrun;

  modport master (
    output ce_1m, wave_in, env_in,
    input  signal_out, done, busy, overrun
  );

  modport slave (
    input  ce_1m, wave_in, env_in,
    output signal_out, done, busy, overrun
  );

endinterface

// File: rtl/sid_dca_mul.sv
// sid_dca_mul -- single registered unsigned WAVE_W x ENV_W multiply stage.
//   clock, reset : system clock, synchronous active-high reset
//   a, b         : waveform sample and envelope operands
//   en           : load q with the scaled product at the next edge
//   q            : top OUT_W bits of the product, 1-clock latency
// Build option: SID_DCA_ROUND_EN adds a half-LSB bias before truncation
// (round-half-up); otherwise the product is plainly truncated.
module sid_dca_mul
  import sid_dca_pkg::*;
#(
  parameter int unsigned WAVE_W = DEF_WAVE_W,
  parameter int unsigned ENV_W  = DEF_ENV_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WAVE_W-1:0] a,
  input  logic [ENV_W-1:0]  b,
  input  logic              en,
  output logic [OUT_W-1:0]  q
);

  localparam int unsigned MUL_W = WAVE_W + ENV_W;

  logic [MUL_W-1:0] product;
  logic [OUT_W-1:0] scaled;

  always_comb begin
    product = MUL_W'(a) * MUL_W'(b);
`ifdef SID_DCA_ROUND_EN
    // Cannot carry out: max operands leave more than the bias of headroom.
    product = product + MUL_W'(round_bias(MUL_W, OUT_W));
`endif
    scaled = OUT_W'(product >> (MUL_W - OUT_W));
  end

  always_ff @(posedge clock) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= scaled;
  end

endmodule

// File: rtl/sid_dca_scheduler.sv
// sid_dca_scheduler -- time-multiplexes one registered DCA multiplier across
// all SID voices. Each accepted ce_1m snapshots every voice's wave/envelope
// pair, multiplies them one voice per clock into a shadow bank, then commits
// every voice output in the same cycle so the mixer sees coherent samples.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : ce_1m, wave_in, env_in in; signal_out, done, busy, overrun out
// Timing for strobe sampled at edge T: product k at T+1+k, shadow k at T+2+k,
// signal_out/done at T+NUM_VOICES+2; next strobe accepted from T+NUM_VOICES+3.
// Build option: SID_DCA_ROUND_EN (rounding in sid_dca_mul, latency unchanged).
module sid_dca_scheduler
  import sid_dca_pkg::*;
#(
  parameter int unsigned NUM_VOICES = DEF_NUM_VOICES,
  parameter int unsigned WAVE_W     = DEF_WAVE_W,
  parameter int unsigned ENV_W      = DEF_ENV_W,
  parameter int unsigned OUT_W      = DEF_OUT_W
) (
  input  logic     clock,
  input  logic     reset,
  sid_dca_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  dca_state_t state, state_next;

  logic             capture;
  logic             issue;
  logic             commit;
  logic [IDX_W-1:0] idx;

  logic [WAVE_W-1:0] snap_wave [NUM_VOICES];
  logic [ENV_W-1:0]  snap_env  [NUM_VOICES];
  logic [OUT_W-1:0]  shadow    [NUM_VOICES];

  // Tracks which voice the multiplier register currently holds, so the
  // shadow write lags the issue by exactly one clock.
  logic             wr_valid;
  logic [IDX_W-1:0] wr_idx;
  logic [OUT_W-1:0] mul_q;

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    issue      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ce_1m) begin
          capture    = 1'b1;
          state_next = MUL;
        end
      end
      MUL: begin
        issue = 1'b1;
        if (idx == LAST_IDX)
          state_next = DRAIN;
      end
      DRAIN: begin
        state_next = COMMIT;
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      idx            <= '0;
      wr_valid       <= 1'b0;
      wr_idx         <= '0;
      bus.signal_out <= '0;
      bus.done       <= 1'b0;
      bus.overrun    <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        snap_wave[i] <= '0;
        snap_env[i]  <= '0;
        shadow[i]    <= '0;
      end
    end else begin
      bus.done <= commit;
      wr_valid <= issue;
      wr_idx   <= idx;

      if (capture) begin
        idx <= '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          snap_wave[i] <= bus.wave_in[i*WAVE_W +: WAVE_W];
          snap_env[i]  <= bus.env_in[i*ENV_W +: ENV_W];
        end
      end else if (issue) begin
        idx <= idx + IDX_W'(1);
      end

      if (wr_valid)
        shadow[wr_idx] <= mul_q;

      if (commit) begin
        for (int unsigned i = 0; i < NUM_VOICES; i++)
          bus.signal_out[i*OUT_W +: OUT_W] <= shadow[i];
      end

      if (bus.ce_1m && (state != IDLE))
        bus.overrun <= 1'b1;
    end
  end

  sid_dca_mul #(
    .WAVE_W (WAVE_W),
    .ENV_W  (ENV_W),
    .OUT_W  (OUT_W)
  ) u_mul (
    .clock (clock),
    .reset (reset),
    .a     (snap_wave[idx]),
    .b     (snap_env[idx]),
    .en    (issue),
    .q     (mul_q)
  );

endmodule

// File: tb/tb_sid_dca_scheduler.sv
// tb_sid_dca_scheduler -- self-checking bench for sid_dca_scheduler
// (3 voices, 12-bit wave, 8-bit envelope, 12-bit output). Expected outputs
// come from a constant vector table and a behavioural reference function;
// they are queued when a pass is launched and popped when done pulses.
// Honours SID_DCA_ROUND_EN for the expected values.
module tb_sid_dca_scheduler;

  localparam int unsigned NV = 3;
  localparam int unsigned WW = 12;
  localparam int unsigned EW = 8;
  localparam int unsigned OW = 12;

  typedef struct {
    logic [NV*WW-1:0] wave;
    logic [NV*EW-1:0] env;
    logic [NV*OW-1:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sid_dca_if #(.NUM_VOICES(NV), .WAVE_W(WW), .ENV_W(EW), .OUT_W(OW)) bus ();

  sid_dca_scheduler #(.NUM_VOICES(NV), .WAVE_W(WW), .ENV_W(EW), .OUT_W(OW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [NV*OW-1:0] exp_q[$];

  function automatic logic [11:0] ref_dca(input logic [11:0] w, input logic [7:0] e);
    logic [19:0] p;
    p = 20'(w) * 20'(e);
`ifdef SID_DCA_ROUND_EN
    p = p + 20'h00080;
`endif
    return p[19:8];
  endfunction

  function automatic logic [NV*OW-1:0] ref_all(input logic [NV*WW-1:0] w,
                                               input logic [NV*EW-1:0] e);
    logic [NV*OW-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++)
      r[v*OW +: OW] = ref_dca(w[v*WW +: WW], e[v*EW +: EW]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic start_pass(input logic [NV*WW-1:0] w, input logic [NV*EW-1:0] e,
                            input logic [NV*OW-1:0] exp);
    @(negedge clock);
    bus.wave_in = w;
    bus.env_in  = e;
    bus.ce_1m   = 1'b1;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    bus.ce_1m = 1'b0;
  endtask

  // Steps clocks until done (bounded). Optionally scrambles inputs every
  // clock and/or raises a stray ce_1m after `extra_ce` cycles.
  task automatic wait_pass(input bit scramble, input int extra_ce,
                           output int lat, output int bcnt, output bit got);
    lat  = 0;
    bcnt = 0;
    got  = 1'b0;
    while (!got && lat < 20) begin
      if (bus.busy) bcnt++;
      bus.ce_1m = (extra_ce >= 0 && lat == extra_ce);
      if (scramble) begin
        bus.wave_in = 36'({$urandom, $urandom});
        bus.env_in  = 24'($urandom);
      end
      @(posedge clock);
      #1;
      lat++;
      if (bus.done) got = 1'b1;
    end
    bus.ce_1m = 1'b0;
  endtask

  task automatic finish_pass(input string name, input bit got, input int lat,
                             input int bcnt, input bit timing);
    logic [NV*OW-1:0] exp;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    if (timing) begin
      check({name, "_latency"}, 64'(lat), 64'd5);
      check({name, "_busy_cycles"}, 64'(bcnt), 64'd5);
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard actual=empty required=entry", name);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_signal_out"}, 64'(bus.signal_out), 64'(exp));
    end
    check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    vec_t tbl[4];
    int   lat, bcnt, dcnt;
    bit   got;
    logic [NV*WW-1:0] w;
    logic [NV*EW-1:0] e;

    tbl[0] = '{wave: {12'h000, 12'h800, 12'hFFF}, env: {8'hFF, 8'h80, 8'hFF},
               exp: {12'h000, 12'h400, 12'hFEF}};
`ifdef SID_DCA_ROUND_EN
    tbl[1] = '{wave: {12'h123, 12'hFFF, 12'h001}, env: {8'h00, 8'hFF, 8'h80},
               exp: {12'h000, 12'hFEF, 12'h001}};
    tbl[2] = '{wave: {12'hFFF, 12'h400, 12'h800}, env: {8'h01, 8'h01, 8'hFF},
               exp: {12'h010, 12'h004, 12'h7F8}};
`else
    tbl[1] = '{wave: {12'h123, 12'hFFF, 12'h001}, env: {8'h00, 8'hFF, 8'h80},
               exp: {12'h000, 12'hFEF, 12'h000}};
    tbl[2] = '{wave: {12'hFFF, 12'h400, 12'h800}, env: {8'h01, 8'h01, 8'hFF},
               exp: {12'h00F, 12'h004, 12'h7F8}};
`endif
    tbl[3] = '{wave: {12'h0F0, 12'h555, 12'hAAA}, env: {8'h10, 8'hAA, 8'h55},
               exp: {12'h00F, 12'h38A, 12'h38A}};

    bus.ce_1m   = 1'b0;
    bus.wave_in = '0;
    bus.env_in  = '0;
    reset       = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_signal_out", 64'(bus.signal_out), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_overrun", 64'(bus.overrun), 64'd0);

    // Table vectors: nominal, boundary and rounding-sensitive operands.
    for (int i = 0; i < 4; i++) begin
      start_pass(tbl[i].wave, tbl[i].env, tbl[i].exp);
      wait_pass(1'b0, -1, lat, bcnt, got);
      finish_pass($sformatf("vec%0d", i), got, lat, bcnt, 1'b1);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_done_width", i), 64'(bus.done), 64'd0);
    end

    // Inputs changing every clock during a pass must not leak in.
    start_pass(tbl[3].wave, tbl[3].env, tbl[3].exp);
    wait_pass(1'b1, -1, lat, bcnt, got);
    finish_pass("scramble", got, lat, bcnt, 1'b1);

    // Stray strobe two clocks into a pass: ignored, overrun latches.
    start_pass(tbl[0].wave, tbl[0].env, tbl[0].exp);
    bus.wave_in = tbl[2].wave;
    bus.env_in  = tbl[2].env;
    wait_pass(1'b0, 1, lat, bcnt, got);
    finish_pass("overrun_pass", got, lat, bcnt, 1'b1);
    check("overrun_set", 64'(bus.overrun), 64'd1);
    start_pass(tbl[1].wave, tbl[1].env, tbl[1].exp);
    wait_pass(1'b0, -1, lat, bcnt, got);
    finish_pass("after_overrun", got, lat, bcnt, 1'b1);
    check("overrun_sticky", 64'(bus.overrun), 64'd1);
    dcnt = 0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (bus.done) dcnt++;
    end
    check("overrun_no_extra_done", 64'(dcnt), 64'd0);

    // Reset in MUL with a coincident strobe: pass aborted, nothing committed.
    start_pass(tbl[2].wave, tbl[2].env, tbl[2].exp);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset     = 1'b1;
    bus.ce_1m = 1'b1;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    bus.ce_1m = 1'b0;
    exp_q.delete();
    check("abort_signal_out", 64'(bus.signal_out), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_overrun", 64'(bus.overrun), 64'd0);
    dcnt = 0;
    repeat (10) begin
      if (bus.done || bus.busy) dcnt++;
      @(posedge clock);
      #1;
    end
    check("abort_quiet", 64'(dcnt), 64'd0);
    check("abort_signal_out_held", 64'(bus.signal_out), 64'd0);

    // Back-to-back passes at the minimum 6-clock strobe spacing.
    for (int n = 0; n < 100; n++) begin
      w = 36'({$urandom, $urandom});
      e = 24'($urandom);
      if (n == 0) begin
        w = {12'hFFF, 12'hFFF, 12'hFFF};
        e = {8'hFF, 8'hFF, 8'hFF};
      end
      start_pass(w, e, ref_all(w, e));
      wait_pass(1'b0, -1, lat, bcnt, got);
      finish_pass($sformatf("rand%0d", n), got, lat, bcnt, (n < 3));
    end
    check("rand_overrun_clear", 64'(bus.overrun), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
